// File: rtl/dvp_capture_if.sv
// Pixel stream leaving the DVP capture block: one-cycle strobe plus data, coordinates and line/frame markers.
interface dvp_capture_if #(
  parameter int PIXEL_WIDTH = 16,
  parameter int X_WIDTH     = 9,
  parameter int Y_WIDTH     = 8
);
  logic                   pix_valid;
  logic [PIXEL_WIDTH-1:0] pix_data;
  logic [X_WIDTH-1:0]     pix_x;
  logic [Y_WIDTH-1:0]     pix_y;
  logic                   sof;
  logic                   eol;

  modport master (output pix_valid, pix_data, pix_x, pix_y, sof, eol);
  modport slave  (input  pix_valid, pix_data, pix_x, pix_y, sof, eol);
endinterface

// File: rtl/dvp_capture.sv
// OV7725 DVP capture in the clk domain: oversampled pclk/href/vsync, RGB565 byte pairing, geometry checks.
// pix_valid lands 3..4 clk after the pin pclk edge of a pixel's second byte; there is no backpressure.
module dvp_capture #(
  parameter int VDATA_WIDTH = 10,
  parameter int ROW_NUM     = 240,
  parameter int PIXEL_NUM   = 320,
  parameter int PIXEL_WIDTH = 16,
  parameter int X_WIDTH     = 9,
  parameter int Y_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   pclk,
  input  logic                   vsync,
  input  logic                   href,
  input  logic [VDATA_WIDTH-1:0] vdata,
  dvp_capture_if.master          pix,
  output logic                   frame_done,
  output logic                   line_err,
  output logic                   frame_err
);

  localparam logic [X_WIDTH-1:0] X_END  = X_WIDTH'(PIXEL_NUM);
  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(PIXEL_NUM - 1);
  localparam logic [X_WIDTH-1:0] X_MAX  = {X_WIDTH{1'b1}};
  localparam logic [Y_WIDTH-1:0] Y_END  = Y_WIDTH'(ROW_NUM);
  localparam logic [Y_WIDTH-1:0] Y_MAX  = {Y_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

  state_t state, next_state;

  logic [1:0] pclk_sr, vs_sr, href_sr;
  logic [7:0] byte_s1, byte_s2;
  logic       pclk_d, vs_d, href_d;

  logic [X_WIDTH-1:0]     x_q, x_n, px_q, px_n;
  logic [Y_WIDTH-1:0]     y_q, y_n, py_q, py_n;
  logic                   ph_q, ph_n;
  logic [7:0]             hi_q, hi_n;
  logic [PIXEL_WIDTH-1:0] pd_q, pd_n;
  logic                   pv_q, pv_n, sof_q, sof_n, eol_q, eol_n;
  logic                   fd_q, fd_n, le_q, le_n, fe_q, fe_n;

  logic pe, href_s, vs_s, href_fall, vs_rise, vs_fall, line_end;

  generate
    if (VDATA_WIDTH > 8) begin : g_low_bits
      logic unused_low_bits;
      assign unused_low_bits = ^vdata[VDATA_WIDTH-9:0];
    end
  endgenerate

  // The byte takes the same two-flop path as the strobes so it is aligned in the pe cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pclk_sr <= '0;
      vs_sr   <= '0;
      href_sr <= '0;
      byte_s1 <= '0;
      byte_s2 <= '0;
      pclk_d  <= 1'b0;
      vs_d    <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      pclk_sr <= {pclk_sr[0], pclk};
      vs_sr   <= {vs_sr[0], vsync};
      href_sr <= {href_sr[0], href};
      byte_s1 <= vdata[VDATA_WIDTH-1 -: 8];
      byte_s2 <= byte_s1;
      pclk_d  <= pclk_sr[1];
      vs_d    <= vs_sr[1];
      href_d  <= href_sr[1];
    end
  end

  assign href_s    = href_sr[1];
  assign vs_s      = vs_sr[1];
  assign pe        = pclk_sr[1] & ~pclk_d;
  assign href_fall = href_d & ~href_s;
  assign vs_rise   = vs_s & ~vs_d;
  assign vs_fall   = ~vs_s & vs_d;
  // A frame ending while href is still high closes the open line first.
  assign line_end  = href_fall | (vs_rise & href_s);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable)  next_state = WAIT_VS;
      WAIT_VS: if (vs_fall) next_state = ACTIVE;
      ACTIVE:  if (vs_rise) next_state = enable ? WAIT_VS : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    x_n   = x_q;
    y_n   = y_q;
    ph_n  = ph_q;
    hi_n  = hi_q;
    pd_n  = pd_q;
    px_n  = px_q;
    py_n  = py_q;
    le_n  = le_q;
    fe_n  = fe_q;
    pv_n  = 1'b0;
    sof_n = 1'b0;
    eol_n = 1'b0;
    fd_n  = 1'b0;
    case (state)
      WAIT_VS: begin
        if (vs_fall) begin
          x_n  = '0;
          y_n  = '0;
          ph_n = 1'b0;
          le_n = 1'b0;
          fe_n = 1'b0;
        end
      end
      ACTIVE: begin
        if (pe && href_s) begin
          ph_n = ~ph_q;
          if (!ph_q) begin
            hi_n = byte_s2;
          end else begin
            if (y_q >= Y_END) begin
              fe_n = 1'b1;
            end else if (x_q >= X_END) begin
              le_n = 1'b1;
            end else begin
              pv_n  = 1'b1;
              pd_n  = PIXEL_WIDTH'({hi_q, byte_s2});
              px_n  = x_q;
              py_n  = y_q;
              sof_n = (x_q == '0) && (y_q == '0);
              eol_n = (x_q == X_LAST);
            end
            if (x_q != X_MAX) x_n = x_q + 1'b1;
          end
        end
        // Empty lines (nothing captured) do not count toward the frame height.
        if (line_end && ((x_n != '0) || ph_n)) begin
          if (ph_n || (x_n != X_END)) le_n = 1'b1;
          x_n  = '0;
          ph_n = 1'b0;
          if (y_q != Y_MAX) y_n = y_q + 1'b1;
        end
        if (vs_rise) begin
          if (y_n != Y_END) fe_n = 1'b1;
          fd_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q   <= '0;
      y_q   <= '0;
      ph_q  <= 1'b0;
      hi_q  <= '0;
      pd_q  <= '0;
      px_q  <= '0;
      py_q  <= '0;
      pv_q  <= 1'b0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      fd_q  <= 1'b0;
      le_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      x_q   <= x_n;
      y_q   <= y_n;
      ph_q  <= ph_n;
      hi_q  <= hi_n;
      pd_q  <= pd_n;
      px_q  <= px_n;
      py_q  <= py_n;
      pv_q  <= pv_n;
      sof_q <= sof_n;
      eol_q <= eol_n;
      fd_q  <= fd_n;
      le_q  <= le_n;
      fe_q  <= fe_n;
    end
  end

  assign pix.pix_valid = pv_q;
  assign pix.pix_data  = pd_q;
  assign pix.pix_x     = px_q;
  assign pix.pix_y     = py_q;
  assign pix.sof       = sof_q;
  assign pix.eol       = eol_q;
  assign frame_done    = fd_q;
  assign line_err      = le_q;
  assign frame_err     = fe_q;

endmodule

// File: tb/tb_dvp_capture.sv
// Directed bench for dvp_capture with a 4x2 frame geometry and clk = 4x pclk.
module tb_dvp_capture;

  logic       clk = 1'b0;
  logic       rstn, enable, pclk, vsync, href;
  logic [9:0] vdata;
  logic       frame_done, line_err, frame_err;

  dvp_capture_if #(.PIXEL_WIDTH(16), .X_WIDTH(3), .Y_WIDTH(2)) pix_if ();

  dvp_capture #(
    .VDATA_WIDTH(10), .ROW_NUM(2), .PIXEL_NUM(4),
    .PIXEL_WIDTH(16), .X_WIDTH(3), .Y_WIDTH(2)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .pclk(pclk), .vsync(vsync),
    .href(href), .vdata(vdata), .pix(pix_if.master),
    .frame_done(frame_done), .line_err(line_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  x;
    logic [1:0]  y;
    logic        sof;
    logic        eol;
    int          lat;
  } pix_t;

  pix_t cap[$];
  int   fd_cnt   = 0;
  int   edge_cnt = 0;
  int   pe_mark  = 0;
  int   total    = 0;
  int   bad      = 0;
  int   bcnt     = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(posedge pclk) pe_mark <= edge_cnt;

  always @(negedge clk) begin
    if (pix_if.pix_valid === 1'b1)
      cap.push_back('{d: pix_if.pix_data, x: pix_if.pix_x, y: pix_if.pix_y,
                      sof: pix_if.sof, eol: pix_if.eol, lat: edge_cnt - pe_mark});
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  function automatic logic [7:0] bval(input int k);
    return 8'h12 + 8'(k * 34);
  endfunction

  task automatic pclk_cyc(input logic h, input logic [7:0] b);
    pclk = 1'b0; href = h; vdata = {b, 2'b00};
    #20; pclk = 1'b1; #20;
  endtask

  task automatic send_line(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      pclk_cyc(1'b1, bval(bcnt));
      bcnt++;
    end
    pclk_cyc(1'b0, 8'h00);
    pclk_cyc(1'b0, 8'h00);
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    pclk_cyc(1'b0, 8'h00); pclk_cyc(1'b0, 8'h00);
    vsync = 1'b0;
    pclk_cyc(1'b0, 8'h00); pclk_cyc(1'b0, 8'h00);
  endtask

  task automatic frame_end();
    vsync = 1'b1;
    pclk_cyc(1'b0, 8'h00); pclk_cyc(1'b0, 8'h00);
    #40;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0; pclk = 1'b0; vsync = 1'b1; href = 1'b0; vdata = '0;
    #30;
    total++; if (pix_if.pix_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", pix_if.pix_valid); end
    total++; if (pix_if.pix_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h want=0", pix_if.pix_data); end
    total++; if ({pix_if.pix_x, pix_if.pix_y, pix_if.sof, pix_if.eol} !== 7'b0) begin bad++; $display("FAIL reset_xy got=%b want=0", {pix_if.pix_x, pix_if.pix_y, pix_if.sof, pix_if.eol}); end
    total++; if ({frame_done, line_err, frame_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {frame_done, line_err, frame_err}); end
    rstn = 1'b1;
    #20;
  endtask

  task automatic test_nominal();
    int base, fd0;
    enable = 1'b1; #40;
    bcnt = 0; base = cap.size(); fd0 = fd_cnt;
    frame_start(); send_line(8); send_line(8); frame_end();
    total++; if (cap.size() - base !== 8) begin bad++; $display("FAIL nom_count got=%0d want=8", cap.size() - base); end
    for (int i = 0; i < 8; i++) begin
      if (base + i < cap.size()) begin
        total++;
        if (cap[base+i].d !== {bval(2*i), bval(2*i+1)} || cap[base+i].x !== 3'(i % 4) || cap[base+i].y !== 2'(i / 4)
            || cap[base+i].sof !== (i == 0) || cap[base+i].eol !== (i % 4 == 3)) begin
          bad++;
          $display("FAIL nom_pix%0d got d=%h x=%0d y=%0d sof=%b eol=%b want d=%h x=%0d y=%0d sof=%b eol=%b", i,
                   cap[base+i].d, cap[base+i].x, cap[base+i].y, cap[base+i].sof, cap[base+i].eol,
                   {bval(2*i), bval(2*i+1)}, i % 4, i / 4, i == 0, i % 4 == 3);
        end
        total++; if (cap[base+i].lat < 3 || cap[base+i].lat > 4) begin bad++; $display("FAIL nom_latency%0d got=%0d want=3..4", i, cap[base+i].lat); end
      end
    end
    if (cap.size() >= base + 8) begin
      total++; if (cap[base].d !== 16'h1234) begin bad++; $display("FAIL nom_first got=%h want=1234", cap[base].d); end
      total++; if (cap[base+7].d !== 16'hEE10) begin bad++; $display("FAIL nom_last got=%h want=ee10", cap[base+7].d); end
    end
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL nom_frame_done got=%0d want=1", fd_cnt - fd0); end
    total++; if ({line_err, frame_err} !== 2'b00) begin bad++; $display("FAIL nom_errs got=%b want=00", {line_err, frame_err}); end
  endtask

  task automatic test_short_line();
    int base, fd0;
    bcnt = 0; base = cap.size(); fd0 = fd_cnt;
    frame_start(); send_line(6);
    total++; if (cap.size() - base !== 3) begin bad++; $display("FAIL short_count got=%0d want=3", cap.size() - base); end
    total++; if (line_err !== 1'b1) begin bad++; $display("FAIL short_line_err got=%b want=1", line_err); end
    send_line(8); frame_end();
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL short_frame_done got=%0d want=1", fd_cnt - fd0); end
    total++; if (line_err !== 1'b1) begin bad++; $display("FAIL short_sticky got=%b want=1", line_err); end
    frame_start();
    total++; if (line_err !== 1'b0) begin bad++; $display("FAIL short_cleared got=%b want=0", line_err); end
    send_line(8); send_line(8); frame_end();
  endtask

  task automatic test_odd_long();
    int base;
    frame_start();
    base = cap.size();
    send_line(7);
    total++; if (cap.size() - base !== 3) begin bad++; $display("FAIL odd_count got=%0d want=3", cap.size() - base); end
    total++; if (line_err !== 1'b1) begin bad++; $display("FAIL odd_line_err got=%b want=1", line_err); end
    send_line(8); frame_end();
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL odd_frame_err got=%b want=0", frame_err); end
    frame_start();
    total++; if (line_err !== 1'b0) begin bad++; $display("FAIL long_cleared got=%b want=0", line_err); end
    base = cap.size();
    send_line(10);
    total++; if (cap.size() - base !== 4) begin bad++; $display("FAIL long_count got=%0d want=4", cap.size() - base); end
    if (cap.size() >= base + 4) begin
      total++; if (cap[base+3].x !== 3'd3 || cap[base+3].eol !== 1'b1) begin bad++; $display("FAIL long_last got x=%0d eol=%b want x=3 eol=1", cap[base+3].x, cap[base+3].eol); end
    end
    total++; if (line_err !== 1'b1) begin bad++; $display("FAIL long_line_err got=%b want=1", line_err); end
    send_line(8); frame_end();
  endtask

  task automatic test_frame_overrun();
    int base, fd0;
    frame_start();
    base = cap.size(); fd0 = fd_cnt;
    send_line(8); send_line(8); send_line(8); frame_end();
    total++; if (cap.size() - base !== 8) begin bad++; $display("FAIL ovr_count got=%0d want=8", cap.size() - base); end
    if (cap.size() >= base + 8) begin
      total++; if (cap[base+7].y !== 2'd1) begin bad++; $display("FAIL ovr_last_y got=%0d want=1", cap[base+7].y); end
    end
    total++; if ({frame_err, line_err} !== 2'b10) begin bad++; $display("FAIL ovr_errs got=%b want=10", {frame_err, line_err}); end
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL ovr_frame_done got=%0d want=1", fd_cnt - fd0); end
  endtask

  task automatic test_enable_drop();
    int base, fd0;
    frame_start();
    base = cap.size(); fd0 = fd_cnt;
    for (int i = 0; i < 4; i++) begin
      pclk_cyc(1'b1, bval(bcnt));
      bcnt++;
    end
    enable = 1'b0;
    send_line(4); send_line(8); frame_end();
    total++; if (cap.size() - base !== 8) begin bad++; $display("FAIL en_count got=%0d want=8", cap.size() - base); end
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL en_frame_done got=%0d want=1", fd_cnt - fd0); end
    base = cap.size(); fd0 = fd_cnt;
    frame_start(); send_line(8); send_line(8); frame_end();
    total++; if (cap.size() - base !== 0) begin bad++; $display("FAIL en_idle_count got=%0d want=0", cap.size() - base); end
    total++; if (fd_cnt - fd0 !== 0) begin bad++; $display("FAIL en_idle_done got=%0d want=0", fd_cnt - fd0); end
  endtask

  task automatic test_reset_midline();
    int base, fd0;
    enable = 1'b1; #40;
    frame_start();
    bcnt = 0;
    for (int i = 0; i < 4; i++) begin
      pclk_cyc(1'b1, bval(bcnt));
      bcnt++;
    end
    #40;
    total++; if (pix_if.pix_data !== 16'h5678 || pix_if.pix_x !== 3'd1) begin bad++; $display("FAIL rst_pre got d=%h x=%0d want d=5678 x=1", pix_if.pix_data, pix_if.pix_x); end
    rstn = 1'b0;
    #1;
    total++; if (pix_if.pix_data !== 16'h0 || pix_if.pix_x !== 3'd0 || pix_if.pix_valid !== 1'b0) begin bad++; $display("FAIL rst_async got d=%h x=%0d v=%b want 0", pix_if.pix_data, pix_if.pix_x, pix_if.pix_valid); end
    #9;
    rstn = 1'b1;
    base = cap.size(); fd0 = fd_cnt;
    send_line(4); send_line(8); frame_end();
    total++; if (cap.size() - base !== 0 || fd_cnt - fd0 !== 0) begin bad++; $display("FAIL rst_wait got pix=%0d done=%0d want 0 0", cap.size() - base, fd_cnt - fd0); end
    frame_start();
    bcnt = 0; base = cap.size(); fd0 = fd_cnt;
    send_line(8); send_line(8); frame_end();
    total++; if (cap.size() - base !== 8) begin bad++; $display("FAIL rst_resume_count got=%0d want=8", cap.size() - base); end
    if (cap.size() > base) begin
      total++;
      if (cap[base].x !== 3'd0 || cap[base].y !== 2'd0 || cap[base].sof !== 1'b1 || cap[base].d !== 16'h1234) begin
        bad++; $display("FAIL rst_resume_first got x=%0d y=%0d sof=%b d=%h want 0 0 1 1234", cap[base].x, cap[base].y, cap[base].sof, cap[base].d);
      end
    end
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL rst_resume_done got=%0d want=1", fd_cnt - fd0); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_odd_long();
    test_frame_overrun();
    test_enable_drop();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dvp_capture.md
Name: dvp_capture

Overview:
- Sits between the OV7725 DVP pins and the frame-store stage; runs entirely in the system clk domain.
- Oversamples pclk, href and vsync, assembles byte pairs into RGB565 pixels and emits a pixel stream with x/y coordinates, start-of-frame, end-of-line and frame-done markers.
- Checks line and frame geometry against ROW_NUM/PIXEL_NUM and flags errors.

Parameters:
- VDATA_WIDTH, 10, camera data bus width; the upper 8 bits carry the byte.
- ROW_NUM, 240, active lines per frame.
- PIXEL_NUM, 320, pixels per line; each pixel is 2 bytes.
- PIXEL_WIDTH, 16, output pixel width (RGB565).
- X_WIDTH, 9, pix_x width; must satisfy 2^X_WIDTH > PIXEL_NUM.
- Y_WIDTH, 8, pix_y width; must satisfy 2^Y_WIDTH > ROW_NUM.

Ports:
- clk  in  1  system clock; must be at least 3x the pclk frequency.
- rstn  in  1  reset.
- enable  in  1  capture enable, level.
- pclk  in  1  camera pixel clock, asynchronous to clk.
- vsync  in  1  camera vertical sync; high between frames.
- href  in  1  camera line valid.
- vdata  in  VDATA_WIDTH  camera data.
- pix_valid  out  1  one-cycle strobe; the pixel outputs below are valid in this cycle.
- pix_data  out  PIXEL_WIDTH  {first byte, second byte}.
- pix_x  out  X_WIDTH  pixel column, 0..PIXEL_NUM-1.
- pix_y  out  Y_WIDTH  pixel row, 0..ROW_NUM-1.
- sof  out  1  high with pix_valid for pixel (0,0).
- eol  out  1  high with pix_valid for pixel x = PIXEL_NUM-1.
- frame_done  out  1  one-cycle pulse at end of frame.
- line_err  out  1  sticky line-geometry error.
- frame_err  out  1  sticky frame-geometry error.

Behaviour:
- Reset: rstn is asynchronous, active-low; the clock is clk. All outputs reset to 0, the state machine to IDLE, and all counters, the byte phase and the synchronisers to 0.
- Synchronisation:
  - pclk, vsync and href each pass through 2 flops.
  - vdata[VDATA_WIDTH-1 -: 8] passes through a matching 2-flop delay, so it stays aligned with the other three signals.
  - A pclk rising edge (pe) is the cycle in which synced pclk is 1 and its previous value was 0.
  - href and the byte are sampled only in pe cycles.
- State machine:
  - IDLE: when enable=1, go to WAIT_VS.
  - WAIT_VS: on a synced vsync falling edge, go to ACTIVE. On this transition clear x, y, byte phase, line_err and frame_err.
  - ACTIVE:
    - A pe with href=1 captures a byte. Phase 0 stores the high byte; phase 1 forms the pixel. The phase toggles on every such pe.
    - pix_valid asserts on the cycle after the phase-1 pe, with pix_data, pix_x and pix_y registered. After each pixel, x increments.
    - Synced href falling edge:
      - Line was non-empty: if phase=1 or x != PIXEL_NUM, set line_err. Then x:=0, phase:=0, y:=y+1.
      - Line was empty (x=0 and phase=0): ignored.
    - Synced vsync rising edge:
      - If y != ROW_NUM, set frame_err.
      - Pulse frame_done for 1 cycle.
      - Next state: WAIT_VS if enable=1, else IDLE.
- Overruns:
  - A pixel with x >= PIXEL_NUM is dropped (no pix_valid) and sets line_err.
  - A line with y >= ROW_NUM drops all its pixels and sets frame_err.
  - Counters saturate and never wrap.
- enable deasserted mid-frame: the current frame completes normally. enable is only sampled in IDLE and at frame end.
- Simultaneous events in one cycle, processed in this order: pixel emit, then href fall, then vsync rise.
  - A vsync rise while href is still high is treated as an implicit href fall first.
- vsync rising while in WAIT_VS is ignored.
- Latency: pix_valid follows the pin-level pclk rising edge of the second byte by 3..4 clk.
- sof and eol are asserted only together with pix_valid. For PIXEL_NUM=1 both can assert together.

Test Plan:
1. Nominal frame, PIXEL_NUM=4, ROW_NUM=2 override, clk = 4x pclk, byte sequence 0x12,0x34,… → 8 pix_valid pulses; first pix_data=0x1234 with sof=1; eol at x=3 for y=0 and y=1; frame_done once; no errors.
2. Short line: 3 pixels with PIXEL_NUM=4 → 3 pix_valid; line_err=1 after href fall; line_err cleared at the next frame's vsync fall.
3. Odd byte count (7 bytes) → 3 pixels emitted, line_err=1. Long line of 5 pixels → 4 emitted, line_err=1.
4. Frame of 3 lines with ROW_NUM=2 → line 3 produces no pix_valid; frame_err=1; frame_done pulses.
5. enable dropped in the middle of line 1 → frame completes with all 8 pixels, frame_done pulses, FSM returns to IDLE; the next frame produces no output.
6. rstn asserted mid-line → all outputs 0 immediately; after release with enable=1, capture resumes only after the next vsync fall, with x=y=0.
